// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word serializer: FSM state codes, default widths,
// and helpers that derive the slice ratio and the slice counter width.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned SLICE_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    function automatic int unsigned slice_ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    function automatic int unsigned slice_cnt_width(input int unsigned in_w, input int unsigned out_w);
        return $clog2(slice_ratio(in_w, out_w));
    endfunction

endpackage

// File: rtl/slice_shifter.sv
// Loadable shift register presenting one OUT_WIDTH slice at a time, with a slice
// counter that flags the final slice of the loaded word.
module slice_shifter
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DATA_WIDTH,
    parameter int unsigned OUT_WIDTH = SLICE_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [IN_WIDTH-1:0]  load_data,
    input  logic                 shift_en,
    output logic [OUT_WIDTH-1:0] slice,
    output logic                 last
);

    localparam int unsigned RATIO = slice_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned CNT_W = slice_cnt_width(IN_WIDTH, OUT_WIDTH);

    logic [IN_WIDTH-1:0] sreg;
    logic [CNT_W-1:0]    cnt;

    // Load restarts the count; each accepted slice moves the next one into view.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= '0;
        end else if (shift_en) begin
            if (MSB_FIRST) sreg <= sreg << OUT_WIDTH;
            else           sreg <= sreg >> OUT_WIDTH;
            cnt <= cnt + CNT_W'(1);
        end
    end

    if (MSB_FIRST) begin : g_msb
        assign slice = sreg[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
        assign slice = sreg[OUT_WIDTH-1:0];
    end

    assign last = (cnt == CNT_W'(RATIO - 1));

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops wide words from the upstream FIFO and streams them out as narrow slices over
// valid/ready, overlapping the next pop with the final slice of the current word.
module fifo_word_serializer
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DATA_WIDTH,
    parameter int unsigned OUT_WIDTH = SLICE_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 r_ready,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy
);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || (IN_WIDTH / OUT_WIDTH) < 2) begin : g_bad_cfg
        $error("fifo_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with a ratio of at least 2");
    end

    logic [1:0]           state;
    logic [1:0]           state_nx;
    logic                 load;
    logic                 shift_en;
    logic [OUT_WIDTH-1:0] slice;
    logic                 last;

    slice_shifter #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_data(fifo_data),
        .shift_en (shift_en),
        .slice    (slice),
        .last     (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Pops are issued only while the FIFO reports data, and never while held in reset.
    always_comb begin
        state_nx = state;
        r_ready  = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !reset) begin
                    r_ready  = 1'b1;
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                load     = 1'b1;
                state_nx = ST_SEND;
            end
            ST_SEND: begin
                if (m_ready) begin
                    shift_en = 1'b1;
                    if (last) begin
                        if (!fifo_empty) begin
                            r_ready  = 1'b1;
                            state_nx = ST_FETCH;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign m_valid = (state == ST_SEND);
    assign m_data  = m_valid ? slice : '0;
    assign m_last  = m_valid && last;
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: a queue-backed FIFO model feeds an MSB-first and an
// LSB-first instance; a slice scoreboard checks order, last flags, timing and reset.
module tb_fifo_word_serializer;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        m_ready;

    logic        r_ready,   m_valid,   m_last,   busy;
    logic [7:0]  m_data;
    logic        r_ready_l, m_valid_l, m_last_l, busy_l;
    logic [7:0]  m_data_l;

    logic [31:0] q[$];
    exp_t        em[$];
    exp_t        el[$];
    int          rr_cyc[$];
    int          xfer_cyc[$];
    int          cyc;
    int          xfers;
    int          total;
    int          bad;

    fifo_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .r_ready(r_ready),
        .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy)
    );

    fifo_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .r_ready(r_ready_l),
        .fifo_data(fifo_data), .m_valid(m_valid_l), .m_ready(m_ready),
        .m_data(m_data_l), .m_last(m_last_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a word in the FIFO model and append its expected slices for both orders.
    task automatic push_word(input logic [31:0] w);
        exp_t e;
        q.push_back(w);
        fifo_empty = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e.l = (k == 3);
            e.d = 8'(w >> (8 * (3 - k)));
            em.push_back(e);
            e.d = 8'(w >> (8 * k));
            el.push_back(e);
        end
    endtask

    // One clock: sample at negedge+1, score transfers, model the FIFO pop after the edge.
    task automatic cycle();
        logic pop;
        #1;
        pop = r_ready;
        check("rready_while_empty", 32'(r_ready & fifo_empty), 32'd0);
        check("rready_l_while_empty", 32'(r_ready_l & fifo_empty), 32'd0);
        if (m_valid) begin
            check("msb_unexpected_slice", 32'(em.size() != 0), 32'd1);
            if (em.size() != 0) begin
                check("msb_data", 32'(m_data), 32'(em[0].d));
                check("msb_last", 32'(m_last), 32'(em[0].l));
                if (m_ready) begin
                    em.delete(0);
                    xfers++;
                    xfer_cyc.push_back(cyc);
                end
            end
        end
        if (m_valid_l) begin
            check("lsb_unexpected_slice", 32'(el.size() != 0), 32'd1);
            if (el.size() != 0) begin
                check("lsb_data", 32'(m_data_l), 32'(el[0].d));
                check("lsb_last", 32'(m_last_l), 32'(el[0].l));
                if (m_ready) el.delete(0);
            end
        end
        if (r_ready) rr_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (pop) begin
            check("pop_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) fifo_data = q.pop_front();
        end
        fifo_empty = (q.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((em.size() != 0 || el.size() != 0 || q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(em.size() + el.size() + q.size()), 32'd0);
        cycle();
        cycle();
        check("idle_after_drain", 32'(busy), 32'd0);
        check("idle_after_drain_l", 32'(busy_l), 32'd0);
    endtask

    task automatic clear_logs();
        rr_cyc.delete();
        xfer_cyc.delete();
    endtask

    initial begin
        int start;
        int n;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        xfers      = 0;
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 32'h0;
        m_ready    = 1'b0;

        #2;
        check("rst_r_ready", 32'(r_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Empty FIFO: nothing may happen.
        for (int i = 0; i < 20; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
            check("empty_r_ready", 32'(r_ready), 32'd0);
            check("empty_m_valid", 32'(m_valid), 32'd0);
            check("empty_busy", 32'(busy), 32'd0);
        end

        // Single word, full-rate consumer.
        clear_logs();
        m_ready = 1'b1;
        push_word(32'h11223344);
        drain(20);
        check("t1_xfer_count", 32'(xfer_cyc.size()), 32'd4);
        check("t1_rr_count", 32'(rr_cyc.size()), 32'd1);
        if (xfer_cyc.size() == 4 && rr_cyc.size() == 1) begin
            check("t1_first_latency", 32'(xfer_cyc[0] - rr_cyc[0]), 32'd2);
            check("t1_back_to_back", 32'(xfer_cyc[3] - xfer_cyc[0]), 32'd3);
        end

        // Two queued words: overlapped pop on the last slice.
        clear_logs();
        push_word(32'hA0B0C0D0);
        push_word(32'h01020304);
        drain(30);
        check("t2_xfer_count", 32'(xfer_cyc.size()), 32'd8);
        check("t2_rr_count", 32'(rr_cyc.size()), 32'd2);
        if (xfer_cyc.size() == 8 && rr_cyc.size() == 2) begin
            check("t2_second_pop_on_last", 32'(rr_cyc[1] - xfer_cyc[3]), 32'd0);
            check("t2_eight_in_ten", 32'(xfer_cyc[7] - rr_cyc[0]), 32'd10);
        end

        // Back-pressure on the second slice.
        start = xfers;
        push_word(32'hDEADBEEF);
        n = 0;
        while (xfers == start && n < 20) begin
            cycle();
            n++;
        end
        check("t3_first_slice_seen", 32'(xfers - start), 32'd1);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", 32'(m_valid), 32'd1);
            check("t3_hold_data", 32'(m_data), 32'h0000_00AD);
            check("t3_hold_last", 32'(m_last), 32'd0);
            cycle();
        end
        check("t3_no_xfer_while_stalled", 32'(xfers - start), 32'd1);
        m_ready = 1'b1;
        drain(20);
        check("t3_total_slices", 32'(xfers - start), 32'd4);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0 && q.size() < 4) push_word($urandom());
            m_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        m_ready = 1'b1;
        drain(200);

        // Reset mid-word after two slices.
        start = xfers;
        push_word(32'hCAFEF00D);
        n = 0;
        while (xfers < start + 2 && n < 20) begin
            cycle();
            n++;
        end
        check("t6_two_slices", 32'(xfers - start), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_m_valid", 32'(m_valid), 32'd0);
        check("t6_async_m_data", 32'(m_data), 32'd0);
        check("t6_async_m_last", 32'(m_last), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_r_ready", 32'(r_ready), 32'd0);
        check("t6_async_m_valid_l", 32'(m_valid_l), 32'd0);
        em.delete();
        el.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t6_post_m_valid", 32'(m_valid), 32'd0);
            check("t6_post_busy", 32'(busy), 32'd0);
            check("t6_post_r_ready", 32'(r_ready), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Sits directly downstream of the team's `fifo` block.
- Drains IN_WIDTH-bit words from the FIFO read port (`fifo_empty` / `r_ready` / `data_out`).
- Emits each word as RATIO = IN_WIDTH/OUT_WIDTH narrow slices on a valid/ready stream toward the byte-oriented consumer.
- Owns all FIFO read sequencing. The FIFO is never popped while empty, and no slice is lost under back-pressure.

Parameters:
- IN_WIDTH, 32, FIFO word width. Must equal the FIFO WIDTH.
- OUT_WIDTH, 8, output slice width. IN_WIDTH % OUT_WIDTH == 0 and IN_WIDTH/OUT_WIDTH >= 2, checked at elaboration.
- MSB_FIRST, 1, 1 = most-significant slice sent first; 0 = least-significant slice first.

Ports:
- clk  in  1  Single clock; all logic on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- r_ready  out  1  FIFO pop request, a one-cycle pulse per word.
- fifo_data  in  IN_WIDTH  FIFO `data_out`.
- m_valid  out  1  Output slice valid.
- m_ready  in  1  Downstream accepts the slice.
- m_data  out  OUT_WIDTH  Output slice.
- m_last  out  1  High with the final slice of each word.
- busy  out  1  High whenever state != IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; `r_ready`, `m_valid`, `m_last`, `busy` = 0; `m_data` = 0; shift register and slice counter = 0.
- FIFO contract: `fifo_data` is valid in the cycle after `r_ready` is sampled high (1-cycle read latency). `r_ready` is asserted only in a cycle where `fifo_empty` is sampled low. This is an invariant.
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - If `!fifo_empty`: drive `r_ready=1` (combinational) and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - Capture `fifo_data` into the shift register and set the slice counter to 0. Go to SEND.
  - `r_ready=0` in this state.
- SEND:
  - `m_valid=1`.
  - `m_data` = current slice: the top OUT_WIDTH bits if MSB_FIRST, else the bottom OUT_WIDTH bits.
  - `m_last` = (counter == RATIO-1).
- Handshake: a slice transfers when `m_valid && m_ready` at the rising edge. On transfer, shift the register by OUT_WIDTH (left if MSB_FIRST, else right) and increment the counter.
- Hold rule: while `m_valid && !m_ready`, `m_data` and `m_last` stay stable. The counter and shift register do not change.
- Word boundary, on transfer with `m_last` high:
  - If `!fifo_empty` in the same cycle: assert `r_ready` and go directly to FETCH (overlapped pop).
  - Otherwise go to IDLE.
- Throughput: RATIO slices per RATIO+1 cycles when `m_ready` is held high and the FIFO stays non-empty.
- Latency: first slice is presented 2 cycles after `fifo_empty` falls in IDLE (`r_ready` cycle, FETCH cycle, slice visible in SEND).
- `m_valid` never depends combinationally on `m_ready`. `m_ready` may toggle arbitrarily, including low on the `m_last` slice; the word then stays in SEND.
- `fifo_empty` rising during SEND has no effect until the word boundary.
- Reset mid-word: the partial word is discarded and no further slices are emitted. The FIFO word already popped is lost; this is intended.
- Counter width: $clog2(RATIO), wrapping only via the word-boundary reload.

Decomposition:
- Package `fifo_pkg`:
  - FSM state enum (IDLE/FETCH/SEND).
  - Default widths DATA_WIDTH=32 and SLICE_WIDTH=8.
  - Function computing RATIO and the counter width.
- One sub-module, `slice_shifter`: the loadable shift register with the MSB_FIRST select and slice counter (load, shift_en → slice, last). The FSM stays in the top level.

Test Plan:
- Reset with `fifo_empty=1` held for 20 cycles → `r_ready` never asserts, `m_valid`=0, `busy`=0.
- FIFO holds 0x11223344, MSB_FIRST=1, `m_ready`=1 → `m_data` sequence 0x11, 0x22, 0x33, 0x44 on consecutive cycles, with `m_last` only on 0x44.
- Two words 0xA0B0C0D0 and 0x01020304 queued, `m_ready`=1:
  - 8 slices in 10 cycles from the first `r_ready`.
  - Second `r_ready` coincides with the 0xD0 transfer.
  - Exactly 2 `r_ready` pulses, and `r_ready` never high while `fifo_empty`.
- Back-pressure: `m_ready` low for 3 cycles on the 2nd slice of 0xDEADBEEF → `m_data` holds 0xAD steady. Sequence completes DE, AD, BE, EF with no drop or duplicate.
- MSB_FIRST=0, word 0x11223344 → 0x44, 0x33, 0x22, 0x11, with `m_last` on 0x11.
- Assert `reset` after the 2nd slice of 0xCAFEF00D → all outputs 0 immediately (asynchronously). After release with FIFO empty, the block stays IDLE with no further slices.
